// File: rtl/and_op_sched_pkg.sv
// Shared types and reset values for the AND-operation scheduler.
package and_op_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam state_t STATE_RST      = IDLE;
    localparam logic   RESP_VALID_RST = 1'b0;
    localparam int     RESP_A_RST     = 0;
    localparam int     RESP_ID_RST    = 0;
    localparam int     PTR_RST        = 0;

    // Next index after idx in a ring of n requesters.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/and_op_sched_pick.sv
// Rotating-priority picker: the first set request at or after ptr (wrapping) wins.
// A constant ptr of zero turns it into a fixed lowest-index-first picker.
module and_op_sched_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(N_REQ);

    logic found;

    // First pass covers indices ptr..N_REQ-1, second pass the wrapped part 0..ptr-1.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (IDX_W'(i) < ptr)) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/and_op_scheduler.sv
// One shared AND unit arbitrated between N_REQ requesters, one operation in flight.
// Define AND_OP_SCHED_RR_EN for round-robin selection; otherwise lowest index wins.
module and_op_scheduler
    import and_op_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    input  logic [N_REQ*WIDTH-1:0]   req_c,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     resp_valid,
    output logic [WIDTH-1:0]         resp_a,
    output logic [$clog2(N_REQ)-1:0] resp_id,
    input  logic                     resp_ready,
    output logic                     state_dbg
);

    localparam int IDX_W = $clog2(N_REQ);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // req_ready is a one-hot grant offered only in IDLE; resp_* hold steady until resp_ready.

    state_t             state;
    state_t             state_nx;
    logic [N_REQ-1:0]   grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   ptr;
    logic               accept;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   op_c;
    logic [WIDTH-1:0]   resp_a_q;
    logic [IDX_W-1:0]   resp_id_q;

    and_op_sched_pick #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req      (req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

`ifdef AND_OP_SCHED_RR_EN
    // ptr holds the index where the next search starts (last granted + 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IDX_W'(PTR_RST);
        end else if (accept) begin
            ptr <= IDX_W'(wrap_inc(int'(grant_idx), N_REQ));
        end
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STATE_RST;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)     state_nx = HOLD;
            HOLD:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // rst_n gates the grant so nothing is offered while reset is held.
    always_comb begin
        req_ready  = '0;
        resp_valid = RESP_VALID_RST;
        if (rst_n && state == IDLE) req_ready = grant;
        if (state == HOLD) resp_valid = 1'b1;
        state_dbg  = state;
    end

    assign accept = |req_ready;

    always_comb begin
        op_b = '0;
        op_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                op_b = req_b[i*WIDTH +: WIDTH];
                op_c = req_c[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_a_q  <= WIDTH'(RESP_A_RST);
            resp_id_q <= IDX_W'(RESP_ID_RST);
        end else if (accept) begin
            resp_a_q  <= op_b & op_c;
            resp_id_q <= grant_idx;
        end
    end

    assign resp_a  = resp_a_q;
    assign resp_id = resp_id_q;

endmodule

// File: tb/tb_and_op_scheduler.sv
// Directed self-checking bench for and_op_scheduler (WIDTH=8, N_REQ=4).
// Expectations follow AND_OP_SCHED_RR_EN when it is defined for the build.
module tb_and_op_scheduler;
    import and_op_sched_pkg::*;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ*WIDTH-1:0] req_c;
    logic [N_REQ-1:0]       req_ready;
    logic                   resp_valid;
    logic [WIDTH-1:0]       resp_a;
    logic [1:0]             resp_id;
    logic                   resp_ready;
    logic                   state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // b = FF_0F_F0_3C, c = 81_FF_AA_0F -> per-slice AND results
    logic [WIDTH-1:0] exp_and [N_REQ] = '{8'h0C, 8'hA0, 8'h0F, 8'h81};
`ifdef AND_OP_SCHED_RR_EN
    int exp_ord [5] = '{0, 1, 2, 3, 0};
    logic [N_REQ-1:0] exp_after_bp = 4'b1000;
    logic [N_REQ-1:0] exp_after_idle = 4'b0100;
`else
    int exp_ord [5] = '{0, 0, 0, 0, 0};
    logic [N_REQ-1:0] exp_after_bp = 4'b0001;
    logic [N_REQ-1:0] exp_after_idle = 4'b0001;
`endif

    always #5 clk = ~clk;

    and_op_scheduler #(
        .WIDTH(WIDTH),
        .N_REQ(N_REQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_a    (resp_a),
        .resp_id   (resp_id),
        .resp_ready(resp_ready),
        .state_dbg (state_dbg)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        resp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1;
        req_b = '1;
        req_c = '1;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_checks++; if (resp_a !== 8'h00) begin n_fail++; $display("FAIL reset_resp_a: got %h expected 00", resp_a); end
        n_checks++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL reset_resp_id: got %0d expected 0", resp_id); end
        n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %b expected IDLE", state_dbg); end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_b = 32'h0000_00F0;
        req_c = 32'h0000_003C;
        req_valid = 4'b0001;
        resp_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL single_resp_valid: got %b expected 1", resp_valid); end
        n_checks++; if (resp_a !== 8'h30) begin n_fail++; $display("FAIL single_resp_a: got %h expected 30", resp_a); end
        n_checks++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL single_resp_id: got %0d expected 0", resp_id); end
        n_checks++; if (state_dbg !== HOLD) begin n_fail++; $display("FAIL single_state: got %b expected HOLD", state_dbg); end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_done: got %b expected 0", resp_valid); end
        resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        req_b = 32'h00AA_0000;
        req_c = 32'h000F_0000;
        req_valid = 4'b0100;
        resp_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_grant: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cycle %0d: got %b expected 1", i, resp_valid); end
            n_checks++; if (resp_a !== 8'h0A) begin n_fail++; $display("FAIL bp_resp_a cycle %0d: got %h expected 0a", i, resp_a); end
            n_checks++; if (resp_id !== 2'd2) begin n_fail++; $display("FAIL bp_resp_id cycle %0d: got %0d expected 2", i, resp_id); end
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_req_ready cycle %0d: got %b expected 0000", i, req_ready); end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", resp_valid); end
        n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL bp_release_state: got %b expected IDLE", state_dbg); end
        n_checks++; if (req_ready !== exp_after_bp) begin n_fail++; $display("FAIL bp_next_grant: got %b expected %b", req_ready, exp_after_bp); end
        req_valid = '0;
        resp_ready = 1'b0;
    endtask

    task automatic test_grant_order();
        logic [N_REQ-1:0] e;
        apply_reset();
        req_b = 32'hFF0F_F03C;
        req_c = 32'h81FF_AA0F;
        resp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = 4'b0001 << exp_ord[k];
            #1;
            n_checks++; if (req_ready !== e) begin n_fail++; $display("FAIL order_grant %0d: got %b expected %b", k, req_ready, e); end
            @(negedge clk);
            #1;
            n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL order_valid %0d: got %b expected 1", k, resp_valid); end
            n_checks++; if (resp_id !== 2'(exp_ord[k])) begin n_fail++; $display("FAIL order_id %0d: got %0d expected %0d", k, resp_id, exp_ord[k]); end
            n_checks++; if (resp_a !== exp_and[exp_ord[k]]) begin n_fail++; $display("FAIL order_a %0d: got %h expected %h", k, resp_a, exp_and[exp_ord[k]]); end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_wrap();
        apply_reset();
        resp_ready = 1'b1;
        req_valid = 4'b1000;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_first_grant: got %b expected 1000", req_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (resp_id !== 2'd3) begin n_fail++; $display("FAIL wrap_first_id: got %0d expected 3", resp_id); end
        req_valid = 4'b1010;
        @(negedge clk);
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_grant: got %b expected 0010", req_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (resp_id !== 2'd1) begin n_fail++; $display("FAIL wrap_id: got %0d expected 1", resp_id); end
        n_checks++; if (resp_a !== 8'hA0) begin n_fail++; $display("FAIL wrap_a: got %h expected a0", resp_a); end
        @(negedge clk);
        req_valid = '0;
        resp_ready = 1'b0;
    endtask

    task automatic test_idle_no_move();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid %0d: got %b expected 0", i, resp_valid); end
            n_checks++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL idle_state %0d: got %b expected IDLE", i, state_dbg); end
        end
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        n_checks++; if (req_ready !== exp_after_idle) begin n_fail++; $display("FAIL idle_ptr_grant: got %b expected %b", req_ready, exp_after_idle); end
        req_valid = '0;
    endtask

    task automatic test_drop();
        @(negedge clk);
        req_valid = 4'b0001;
        resp_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL drop_grant: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL drop_hold_ready: got %b expected 0000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        resp_ready = 1'b1;
        #1;
        n_checks++; if (resp_id !== 2'd0) begin n_fail++; $display("FAIL drop_resp_id: got %0d expected 0", resp_id); end
        n_checks++; if (resp_a !== 8'h0C) begin n_fail++; $display("FAIL drop_resp_a: got %h expected 0c", resp_a); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL drop_no_serve %0d: got %b expected 0", i, resp_valid); end
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_reset_in_hold();
        @(negedge clk);
        req_valid = 4'b0010;
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL rh_hold_valid: got %b expected 1", resp_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rh_async_drop: got %b expected 0", resp_valid); end
        n_checks++; if (resp_a !== 8'h00) begin n_fail++; $display("FAIL rh_resp_a: got %h expected 00", resp_a); end
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rh_no_response %0d: got %b expected 0", i, resp_valid); end
        end
        resp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_grant_order();
        test_wrap();
        test_idle_no_move();
        test_drop();
        test_reset_in_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
